// File: rtl/sca_trigger_gen.sv
// Multi-channel trigger generator: each START rising edge launches one pulse per enabled
// channel with its own delay, width and polarity. It also measures the BUSY window length.
module sca_trigger_gen #(
  parameter int NCH   = 3,
  parameter int CNT_W = 16,
  parameter int LEN_W = 9
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 START,
  input  logic                 BUSY,
  input  logic [NCH-1:0]       CFG_EN,
  input  logic [NCH-1:0]       CFG_POL,
  input  logic [NCH*CNT_W-1:0] CFG_DELAY,
  input  logic [NCH*CNT_W-1:0] CFG_WIDTH,
  input  logic                 CLR_OVR,
  output logic [NCH-1:0]       TRIG,
  output logic                 ACTIVE,
  output logic                 TRIG_DONE,
  output logic                 OVERRUN,
  output logic [LEN_W-1:0]     BUSY_LEN
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } ch_state_e;

  logic             start_q;
  logic             start_edge;
  logic             fire;
  logic [NCH-1:0]   ch_busy;
  logic             active_q;
  logic             trig_done_q;
  logic             overrun_q;
  logic             overrun_d;
  logic             busy_q;
  logic [LEN_W-1:0] bcnt_q;
  logic [LEN_W-1:0] bcnt_d;
  logic [LEN_W-1:0] busy_len_q;
  logic [LEN_W-1:0] busy_len_d;

  assign start_edge = START & ~start_q;
  assign ACTIVE     = |ch_busy;
  // An edge during any activity is ignored by all channels so they stay phase-coherent.
  assign fire       = start_edge & ~ACTIVE;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      start_q <= 1'b0;
    end else begin
      start_q <= START;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wid_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;

    assign cfg_delay  = CFG_DELAY[i*CNT_W +: CNT_W];
    assign cfg_width  = CFG_WIDTH[i*CNT_W +: CNT_W];
    assign ch_busy[i] = (state_q != ST_IDLE);
    assign TRIG[i]    = pulse_q ^ CFG_POL[i];

    // NOTE: the counters are plain flops, not RAM, so they are reset with the FSM.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        wid_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (fire && CFG_EN[i] && (cfg_width != '0)) begin
              wid_q <= cfg_width;
              if (cfg_delay == '0) begin
                state_q <= ST_PULSE;
                pulse_q <= 1'b1;
              end else begin
                state_q <= ST_DELAY;
                cnt_q   <= cfg_delay;
              end
            end
          end
          ST_DELAY: begin
            // Leaving at cnt==1 puts the first pulse cycle exactly delay cycles after launch.
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_PULSE;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_PULSE: begin
            if (wid_q == CNT_W'(1)) begin
              state_q <= ST_IDLE;
              pulse_q <= 1'b0;
            end else begin
              wid_q <= wid_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    overrun_d  = overrun_q;
    bcnt_d     = bcnt_q;
    busy_len_d = busy_len_q;
    if (start_edge && ACTIVE) begin
      overrun_d = 1'b1;
    end else if (CLR_OVR) begin
      overrun_d = 1'b0;
    end
    if (BUSY && !busy_q) begin
      bcnt_d = LEN_W'(1);
    end else if (BUSY && (bcnt_q != '1)) begin
      bcnt_d = bcnt_q + LEN_W'(1);
    end
    if (!BUSY && busy_q) begin
      busy_len_d = bcnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      active_q    <= 1'b0;
      trig_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      bcnt_q      <= '0;
      busy_len_q  <= '0;
    end else begin
      active_q    <= ACTIVE;
      trig_done_q <= active_q & ~ACTIVE;
      overrun_q   <= overrun_d;
      busy_q      <= BUSY;
      bcnt_q      <= bcnt_d;
      busy_len_q  <= busy_len_d;
    end
  end

  assign TRIG_DONE = trig_done_q;
  assign OVERRUN   = overrun_q;
  assign BUSY_LEN  = busy_len_q;

endmodule

// File: tb/tb_sca_trigger_gen.sv
// Scoreboard bench for sca_trigger_gen: a cycle-level reference model predicts pulse
// windows and status outputs; an independent monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_sca_trigger_gen;

  localparam int NCH      = 3;
  localparam int CNT_W    = 16;
  localparam int LEN_W    = 9;
  localparam int BLEN_MAX = (1 << LEN_W) - 1;

  logic                 CLK = 1'b0;
  logic                 RSTn;
  logic                 START;
  logic                 BUSY;
  logic [NCH-1:0]       CFG_EN;
  logic [NCH-1:0]       CFG_POL;
  logic [NCH*CNT_W-1:0] CFG_DELAY;
  logic [NCH*CNT_W-1:0] CFG_WIDTH;
  logic                 CLR_OVR;
  logic [NCH-1:0]       TRIG;
  logic                 ACTIVE;
  logic                 TRIG_DONE;
  logic                 OVERRUN;
  logic [LEN_W-1:0]     BUSY_LEN;

  always #5 CLK = ~CLK;

  sca_trigger_gen #(.NCH(NCH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .BUSY(BUSY),
    .CFG_EN(CFG_EN), .CFG_POL(CFG_POL), .CFG_DELAY(CFG_DELAY), .CFG_WIDTH(CFG_WIDTH),
    .CLR_OVR(CLR_OVR), .TRIG(TRIG), .ACTIVE(ACTIVE), .TRIG_DONE(TRIG_DONE),
    .OVERRUN(OVERRUN), .BUSY_LEN(BUSY_LEN)
  );

  typedef struct {
    int start;
    int width;
  } pulse_t;

  typedef struct {
    int   cyc;
    logic act;
    logic ovr;
    int   blen;
    logic done;
  } snap_t;

  pulse_t exp_pulse[NCH][$];
  snap_t  snap_q[$];
  int     m_done_q[$];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: absolute-cycle activity window and status values.
  logic m_start_prev, m_busy_prev, m_ovr;
  int   m_act_begin, m_act_end, m_run, m_blen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_active(input int c);
    return (c >= m_act_begin) && (c <= m_act_end);
  endfunction

  task automatic model_reset();
    m_start_prev = 1'b0;
    m_busy_prev  = 1'b0;
    m_ovr        = 1'b0;
    m_blen       = 0;
    m_run        = 0;
    m_act_begin  = 0;
    m_act_end    = -100;
    m_done_q.delete();
  endtask

  task automatic set_cfg(input int ch, input bit en, input int d, input int w);
    CFG_EN[ch]                   = en;
    CFG_DELAY[ch*CNT_W +: CNT_W] = CNT_W'(d);
    CFG_WIDTH[ch*CNT_W +: CNT_W] = CNT_W'(w);
  endtask

  // Evaluate the model for the inputs of the current cycle, queue expectations for the
  // next cycle, then advance to just after the next rising edge.
  task automatic step();
    snap_t s;
    int    c;
    int    last;
    int    d;
    int    w;
    bit    set_ovr;
    logic  ovr_n;
    int    blen_n;
    logic  done_n;
    c       = cyc;
    set_ovr = 1'b0;
    if (!RSTn) begin
      model_reset();
      s = '{c + 1, 1'b0, 1'b0, 0, 1'b0};
    end else begin
      if (START && !m_start_prev) begin
        if (m_active(c)) begin
          set_ovr = 1'b1;
        end else begin
          last = -1;
          for (int i = 0; i < NCH; i++) begin
            d = int'(CFG_DELAY[i*CNT_W +: CNT_W]);
            w = int'(CFG_WIDTH[i*CNT_W +: CNT_W]);
            if (CFG_EN[i] && (w != 0)) begin
              exp_pulse[i].push_back('{c + 1 + d, w});
              if (c + d + w > last) last = c + d + w;
            end
          end
          if (last >= 0) begin
            m_act_begin = c + 1;
            m_act_end   = last;
            m_done_q.push_back(last + 2);
          end
        end
      end
      ovr_n  = set_ovr ? 1'b1 : (CLR_OVR ? 1'b0 : m_ovr);
      blen_n = m_blen;
      if (BUSY) m_run = m_busy_prev ? m_run + 1 : 1;
      else if (m_busy_prev) blen_n = (m_run > BLEN_MAX) ? BLEN_MAX : m_run;
      done_n = 1'b0;
      if (m_done_q.size() > 0 && m_done_q[0] == c + 1) begin
        done_n = 1'b1;
        void'(m_done_q.pop_front());
      end
      s = '{c + 1, m_active(c + 1), ovr_n, blen_n, done_n};
      m_start_prev = START;
      m_busy_prev  = BUSY;
      m_ovr        = ovr_n;
      m_blen       = blen_n;
    end
    snap_q.push_back(s);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset in the current cycle; outputs must drop at once.
  task automatic apply_reset(input int n);
    RSTn = 1'b0;
    model_reset();
    snap_q.delete();
    for (int i = 0; i < NCH; i++) exp_pulse[i].delete();
    snap_q.push_back('{cyc, 1'b0, 1'b0, 0, 1'b0});
    #1;
    check("rst_trig", 32'(TRIG), 32'(CFG_POL));
    check("rst_active", 32'(ACTIVE), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);
    check("rst_done", 32'(TRIG_DONE), 32'd0);
    idle(n);
    RSTn = 1'b1;
  endtask

  task automatic rand_cfg(input bit with_pol);
    for (int i = 0; i < NCH; i++) begin
      set_cfg(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 20), $urandom_range(0, 10));
    end
    if (with_pol) CFG_POL = NCH'($urandom_range(0, (1 << NCH) - 1));
  endtask

  // Monitor: status outputs against queued snapshots, pulses against expected windows.
  initial begin
    bit     in_p[NCH];
    int     p_start[NCH];
    snap_t  s;
    pulse_t p;
    logic   act;
    for (int i = 0; i < NCH; i++) begin
      in_p[i]    = 1'b0;
      p_start[i] = 0;
    end
    forever begin
      @(negedge CLK);
      if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
        s = snap_q.pop_front();
        check("active", 32'(ACTIVE), 32'(s.act));
        check("overrun", 32'(OVERRUN), 32'(s.ovr));
        check("busy_len", 32'(BUSY_LEN), 32'(s.blen));
        check("trig_done", 32'(TRIG_DONE), 32'(s.done));
      end
      if (!RSTn) begin
        for (int i = 0; i < NCH; i++) in_p[i] = 1'b0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          act = TRIG[i] ^ CFG_POL[i];
          if (act === 1'b1 && !in_p[i]) begin
            in_p[i]    = 1'b1;
            p_start[i] = cyc;
          end else if (act !== 1'b1 && in_p[i]) begin
            in_p[i] = 1'b0;
            p = (exp_pulse[i].size() > 0) ? exp_pulse[i].pop_front() : '{-1, -1};
            check($sformatf("pulse_start_ch%0d", i), p_start[i], p.start);
            check($sformatf("pulse_width_ch%0d", i), cyc - p_start[i], p.width);
          end
        end
      end
    end
  end

  initial begin
    int pending;
    RSTn      = 1'b0;
    START     = 1'b0;
    BUSY      = 1'b0;
    CLR_OVR   = 1'b0;
    CFG_EN    = '0;
    CFG_POL   = 3'b101;
    CFG_DELAY = '0;
    CFG_WIDTH = '0;
    apply_reset(3);
    idle(2);

    // Three channels: immediate, delayed, disabled; a retrigger at t+3 raises OVERRUN.
    CFG_POL = 3'b000;
    set_cfg(0, 1, 0, 1);
    set_cfg(1, 1, 5, 3);
    set_cfg(2, 0, 7, 7);
    START = 1'b1; step();
    START = 1'b0; idle(2);
    START = 1'b1; step();
    START = 1'b0; idle(12);
    CLR_OVR = 1'b1; step();
    CLR_OVR = 1'b0; idle(3);

    // Overrun and clear in the same cycle: OVERRUN must stay set.
    START = 1'b1; step();
    START = 1'b0; idle(2);
    START = 1'b1; CLR_OVR = 1'b1; step();
    START = 1'b0; CLR_OVR = 1'b0; idle(2);
    check("ovr_set_beats_clr", 32'(OVERRUN), 32'd1);
    idle(10);
    CLR_OVR = 1'b1; step();
    CLR_OVR = 1'b0; idle(2);

    // Active-low channel 1.
    CFG_POL = 3'b010;
    set_cfg(0, 0, 0, 0);
    set_cfg(1, 1, 2, 4);
    set_cfg(2, 0, 0, 0);
    START = 1'b1; step();
    START = 1'b0; idle(10);

    // Zero width on every enabled channel: nothing starts.
    for (int i = 0; i < NCH; i++) set_cfg(i, 1, i * 3, 0);
    START = 1'b1; step();
    START = 1'b0; idle(6);

    // BUSY windows: 10, 600 (saturating), 1.
    BUSY = 1'b1; idle(10);
    BUSY = 1'b0; idle(3);
    BUSY = 1'b1; idle(600);
    BUSY = 1'b0; idle(3);
    BUSY = 1'b1; step();
    BUSY = 1'b0; idle(3);

    // Reset during a long delay aborts the channel; no pulse until a new edge.
    CFG_POL = 3'b011;
    set_cfg(0, 0, 0, 0);
    set_cfg(1, 1, 100, 3);
    set_cfg(2, 0, 0, 0);
    START = 1'b1; step();
    START = 1'b0; idle(20);
    apply_reset(3);
    idle(150);
    START = 1'b1; step();
    START = 1'b0; idle(110);

    // Randomized traffic, including retriggers and config changes on running channels.
    for (int k = 0; k < 3000; k++) begin
      if (!m_active(cyc) && $urandom_range(0, 29) == 0) rand_cfg(1'b1);
      else if ($urandom_range(0, 49) == 0) rand_cfg(1'b0);
      if ($urandom_range(0, 5) == 0) START = ~START;
      if ($urandom_range(0, 7) == 0) BUSY = ~BUSY;
      CLR_OVR = ($urandom_range(0, 15) == 0);
      step();
    end
    START   = 1'b0;
    BUSY    = 1'b0;
    CLR_OVR = 1'b0;
    idle(40);

    pending = 0;
    for (int i = 0; i < NCH; i++) pending += exp_pulse[i].size();
    check("pulses_outstanding", pending, 0);
    check("done_outstanding", m_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
